key_fifo: RTL and testbench

KEY_FIFO -- requirements
Module: key_fifo

---
 rtl/key_pkg.sv | 45 ++++
 rtl/key_fifo_mem.sv | 27 ++
 rtl/key_fifo.sv | 173 +++++++++++++++++
 tb/tb_key_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Keypad FIFO shared definitions: register map, bit positions, constants.
// Imported by the FIFO top and its storage sub-module.
package key_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam logic [31:0] OFS_DATA   = 32'h0;
  localparam logic [31:0] OFS_STATUS = 32'h4;
  localparam logic [31:0] OFS_CTRL   = 32'h8;
  localparam logic [31:0] OFS_RSVD   = 32'hC;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 4;
  localparam int ST_CNT_W = 5;

  localparam int CT_IRQ_EN  = 0;
  localparam int CT_FLUSH   = 1;
  localparam int CT_OVF_CLR = 2;

  localparam int INVALID_KEY = 15;
  localparam logic [31:0] EMPTY_READ = 32'h0000_000F;

  function automatic logic [31:0] status_word(
    input logic       empty,
    input logic       full,
    input logic       ovf,
    input logic [4:0] cnt
  );
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY] = empty;
    w[ST_FULL] = full;
    w[ST_OVF] = ovf;
    w[ST_CNT +: ST_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/key_fifo_mem.sv
// Keycode storage: DEPTH x DW, synchronous write port,
// asynchronous read of the head entry.
module key_fifo_mem
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/key_fifo.sv
// Keypad FIFO with Wishbone classic slave: edge-detected key capture,
// DATA/STATUS/CTRL registers, overflow flag and level interrupt.
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_strobe,
  input  logic [DW-1:0] key_data,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          key_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DW-1:0] KEY_BAD  = DW'(INVALID_KEY);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          ack_q;
  logic          strobe_q;
  logic          armed_q;
  logic          irq_q;
  logic [31:0]   dat_q, dat_d;

  logic [DW-1:0] head;
  logic          acc, rd, wr;
  logic          empty, full;
  logic          key_edge, push_req;
  logic          pop, push, drop;
  logic          ctrl_wr, flush, ovf_clr;
  reg_sel_e      sel;
  logic          unused_sigs;

  assign unused_sigs = ^{wb_sel_i, wb_adr_i[31:4],
                         wb_adr_i[1:0], wb_dat_i[31:3]};

  assign sel   = reg_sel_e'(wb_adr_i[3:2]);
  assign acc   = wb_stb_i & wb_cyc_i & ~ack_q;
  assign rd    = acc & ~wb_we_i;
  assign wr    = acc & wb_we_i;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);

  // armed_q blocks a key held through reset until it has been seen released
  assign key_edge = key_strobe & ~strobe_q & armed_q;
  assign push_req = key_edge & (key_data != KEY_BAD);

  assign ctrl_wr = wr & (sel == REG_CTRL);
  assign flush   = ctrl_wr & wb_dat_i[CT_FLUSH];
  assign ovf_clr = ctrl_wr & wb_dat_i[CT_OVF_CLR];

  assign pop  = rd & (sel == REG_DATA) & ~empty;
  assign push = push_req & ~flush & (~full | pop);
  assign drop = push_req & ~flush & full & ~pop;

  key_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (key_data),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    dat_d    = dat_q;

    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (push) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (push & ~pop) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (pop & ~push) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    // a drop in the same cycle as a clear still leaves OVF set
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    if (ctrl_wr) begin
      irq_en_d = wb_dat_i[CT_IRQ_EN];
    end

    if (rd) begin
      unique case (sel)
        REG_DATA: begin
          dat_d = empty ? EMPTY_READ : 32'(head);
        end
        REG_STATUS: begin
          dat_d = status_word(empty, full, ovf_q, 5'(cnt_q));
        end
        REG_CTRL: begin
          dat_d = 32'(irq_en_q);
        end
        REG_RSVD: begin
          dat_d = '0;
        end
        default: begin
          dat_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
      irq_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      ack_q    <= acc;
      strobe_q <= key_strobe;
      armed_q  <= armed_q | ~key_strobe;
      irq_q    <= irq_en_q & (~empty | ovf_q);
      dat_q    <= dat_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign key_irq  = irq_q;

endmodule

// File: tb/tb_key_fifo.sv
// Directed bench for key_fifo: key model queue as scoreboard,
// immediate assertions at every comparison point.
module tb_key_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_strobe = 1'b0;
  logic [3:0]  key_data = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        key_irq;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [3:0]  model[$];
  logic        ovf_m = 1'b0;
  logic [31:0] rdat;
  logic [31:0] exp_d;

  key_fifo #(
    .DEPTH (DEPTH),
    .DW    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_strobe (key_strobe),
    .key_data   (key_data),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .key_irq    (key_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] w;
    int          n;
    n = model.size();
    w = '0;
    w[0] = (n == 0);
    w[1] = (n == DEPTH);
    w[2] = ovf_m;
    w[8:4] = 5'(n);
    return w;
  endfunction

  task automatic model_push(input logic [3:0] k);
    if (k != 4'hF) begin
      if (model.size() < DEPTH) model.push_back(k);
      else ovf_m = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_pop();
    if (model.size() == 0) return 32'h0000_000F;
    return 32'(model.pop_front());
  endfunction

  task automatic press(input logic [3:0] k);
    key_data = k;
    key_strobe = 1'b1;
    @(posedge clk); #1;
    key_strobe = 1'b0;
    @(posedge clk); #1;
    model_push(k);
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr,
                           input logic [31:0] wd,
                           output logic [31:0] rd);
    logic got;
    got = 1'b0;
    wb_adr_i = adr;
    wb_we_i = we;
    wb_dat_i = wd;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    rd = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_status(input string tag);
    wb_access(1'b0, 32'h4, '0, rdat);
    check(tag, rdat, exp_status());
  endtask

  task automatic read_data(input string tag);
    wb_access(1'b0, 32'h0, '0, rdat);
    check(tag, rdat, model_pop());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a key already held
    key_strobe = 1'b1;
    key_data = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_ack", 32'(wb_ack_o), 32'h0);
    check("rst_irq", 32'(key_irq), 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    read_status("held_key_no_push");
    key_strobe = 1'b0;
    @(posedge clk); #1;
    read_status("release_no_push");
    read_data("empty_read");
    wb_access(1'b0, 32'hC, '0, rdat);
    check("rsvd_read", rdat, 32'h0);

    // three presses, invalid key, three reads
    press(4'd1);
    press(4'd2);
    press(4'd3);
    read_status("cnt3");
    press(4'hF);
    read_status("invalid_key");
    read_data("rd1");
    read_data("rd2");
    read_data("rd3");
    read_status("empty_again");

    // overflow
    for (int k = 1; k <= 9; k++) press(4'(k));
    read_status("full_ovf");
    for (int i = 0; i < DEPTH; i++) read_data("rd_full");
    read_status("drained_ovf");
    wb_access(1'b1, 32'h8, 32'h4, rdat);
    ovf_m = 1'b0;
    read_status("ovf_clr");

    // read and key edge in the same cycle on empty FIFO
    key_data = 4'd7;
    key_strobe = 1'b1;
    wb_adr_i = 32'h0;
    wb_we_i = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("simul_ack", 32'(wb_ack_o), 32'd1);
    check("simul_empty_rd", wb_dat_o, 32'h0000_000F);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    key_strobe = 1'b0;
    @(posedge clk); #1;
    model_push(4'd7);
    read_status("simul_cnt1");
    read_data("rd7");

    // interrupt
    wb_access(1'b1, 32'h8, 32'h1, rdat);
    wb_access(1'b0, 32'h8, '0, rdat);
    check("ctrl_rd", rdat, 32'h1);
    key_data = 4'd4;
    key_strobe = 1'b1;
    @(posedge clk); #1;
    check("irq_lat0", 32'(key_irq), 32'h0);
    key_strobe = 1'b0;
    @(posedge clk); #1;
    model_push(4'd4);
    check("irq_set", 32'(key_irq), 32'h1);
    read_data("rd4");
    check("irq_clr", 32'(key_irq), 32'h0);
    wb_access(1'b1, 32'h8, 32'h0, rdat);

    // pop and push together while full
    for (int k = 1; k <= 8; k++) press(4'(k));
    exp_d = model_pop();
    key_data = 4'd9;
    key_strobe = 1'b1;
    wb_adr_i = 32'h0;
    wb_we_i = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("full_simul_rd", wb_dat_o, exp_d);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    key_strobe = 1'b0;
    @(posedge clk); #1;
    model_push(4'd9);
    read_status("full_simul_status");

    // flush
    wb_access(1'b1, 32'h8, 32'h2, rdat);
    model.delete();
    read_status("flush_full");
    for (int k = 1; k <= 5; k++) press(4'(k));
    read_status("cnt5");
    key_data = 4'd6;
    key_strobe = 1'b1;
    wb_adr_i = 32'h8;
    wb_dat_i = 32'h2;
    wb_we_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("flush_ack", 32'(wb_ack_o), 32'd1);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i = 1'b0;
    key_strobe = 1'b0;
    @(posedge clk); #1;
    model.delete();
    read_status("flush_push_dropped");
    wb_access(1'b0, 32'h8, '0, rdat);
    check("ctrl_selfclr", rdat, 32'h0);

    // reset in the middle of a read
    wb_access(1'b1, 32'h8, 32'h1, rdat);
    press(4'd2);
    press(4'd3);
    check("irq_pre_rst", 32'(key_irq), 32'h1);
    wb_adr_i = 32'h0;
    wb_we_i = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(wb_ack_o), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_ack", 32'(wb_ack_o), 32'h0);
    check("mid_rst_dat", wb_dat_o, 32'h0);
    check("mid_rst_irq", 32'(key_irq), 32'h0);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model.delete();
    ovf_m = 1'b0;
    @(posedge clk); #1;
    read_status("post_rst_status");
    wb_access(1'b0, 32'h8, '0, rdat);
    check("post_rst_ctrl", rdat, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
